adder_seq_nbit: RTL and testbench
=================================

Name: adder_seq_nbit

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the fixed 32-bit combinational adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through a rippling chunk carry, under a start/busy/done handshake.
- Adds a subtract mode and the carry, signed-overflow and zero flags.
- Sits in the datapath wherever area matters more than single-cycle latency, e.g. a multi-cycle ALU.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits summed per cycle. N = WIDTH/CHUNK is the number of compute cycles; 1 <= N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- carry_in  input  1  carry into bit 0 when sub=0; ignored when sub=1.
- sub  input  1  0 = a+b+carry_in; 1 = a-b (computed as a + ~b + 1). Captured with start.
- busy  output  1  high while an operation is accepted and not yet complete.
- done  output  1  one-cycle pulse: result registers were just updated.
- out  output  WIDTH  result; holds its value between operations.
- carry_out  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  out == 0.

Behaviour:
- Reset (any state, including mid-operation): state=IDLE, busy=0, done=0, out=0, carry_out=0, overflow=0, zero=0, chunk index=0. Takes effect at the next edge. Reset has priority over start.
- States: IDLE, BUSY, DONE.
- IDLE, start=1 at edge E0:
  - latch a into an internal register;
  - latch b, or ~b when sub=1, into an internal register;
  - chunk carry <= (sub ? 1 : carry_in); chunk index <= 0;
  - go to BUSY; busy=1 from E0.
- IDLE, start=0: stay in IDLE.
- BUSY, each edge:
  - sum chunk k = bits [k*CHUNK +: CHUNK] of the latched operands plus the chunk carry;
  - write the chunk sum into the partial-result register; update the chunk carry; k <= k+1.
  - On the final chunk (k = N-1), also record the carry into the MSB, for overflow.
- Completion: edge E0+N processes the last chunk. In the same edge:
  - out, carry_out, overflow and zero load from the partial result;
  - state goes to DONE; busy <= 0; done <= 1.
- DONE: done=1 for exactly one cycle, then the next edge returns to IDLE with done <= 0. start is ignored in DONE.
- Outputs out/carry_out/overflow/zero change only at the completion edge or on reset; never mid-operation.
- start while busy or in DONE is ignored. Operand and sub inputs are don't-care outside the accepting edge.
- Latency: start accepted at E0; result and done visible after edge E0+N. Throughput is one operation per N+2 cycles.
- Width rules: all arithmetic is modulo 2^WIDTH. carry_out is the true (WIDTH+1)-th bit. No saturation.
- N=1 (CHUNK=WIDTH): a single BUSY cycle; timing rules unchanged.

Test Plan:
- Defaults (WIDTH=32, CHUNK=8). Start with a=0x00000002, b=0x00000003, cin=0, sub=0 at E0 -> busy=1 on edges E0..E0+3; at E0+4: out=0x00000005, carry_out=0, overflow=0, zero=0, done=1 for one cycle.
- a=0xFFFFFFFF, b=0xFFFFFFFF, cin=0 -> out=0xFFFFFFFE, carry_out=1, overflow=0. Repeat with cin=1 -> out=0xFFFFFFFF, carry_out=1.
- a=0x7FFFFFFF, b=0x00000001, add -> out=0x80000000, overflow=1, carry_out=0.
- Subtract cases:
  - sub=1, a=b=0x00000005 -> out=0, zero=1, carry_out=1, overflow=0.
  - sub=1, a=0x80000000, b=1 -> out=0x7FFFFFFF, overflow=1, carry_out=1.
- Reset and ignored start:
  - assert reset at E0+2 of an operation -> after that edge busy=0, done=0, out=0, state IDLE;
  - a new start then completes normally;
  - a start pulsed during BUSY or DONE changes nothing.
- Parameter sweep:
  - WIDTH=16, CHUNK=4: 0x4844 + 0x2222 -> out=0x6A66, done at E0+4;
  - WIDTH=16, CHUNK=16: same operands -> done at E0+1;
  - randomised 1000 operations checked against a+b+cin / a-b reference in both configurations.

Source files
------------

// File: rtl/adder_seq_nbit.sv
// Multi-cycle adder/subtractor: sums a WIDTH-bit operand pair CHUNK bits per clock
// through a rippling chunk carry, under a start/busy/done handshake.
module adder_seq_nbit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    int unsigned      offset;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        out_d   = out_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        offset    = 32'(idx_q) * CHUNK;
        a_chunk   = a_q[offset +: CHUNK];
        b_chunk   = b_q[offset +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    // Subtract is a + ~b + 1; the +1 enters as the initial chunk carry.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : carry_in;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                part_d[offset +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d                 = chunk_sum[CHUNK];
                idx_d                   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    out_d   = part_d;
                    cout_d  = chunk_sum[CHUNK];
                    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
                    ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ part_d[WIDTH-1] ^ chunk_sum[CHUNK];
                    zero_d  = (part_d == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out       = out_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_seq_nbit.sv
// Scoreboard bench for adder_seq_nbit in three configurations: 32/8, 16/4 and 16/16.
module tb_adder_seq_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        int          e0;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [31:0] held0 = '0;

    // 32-bit instance
    logic        reset0, start0, cin0, sub0;
    logic [31:0] a0, b0, out0;
    logic        busy0, done0, cout0, ovf0, zero0;

    // Shared stimulus for the two 16-bit instances
    logic        reset16, start16, cin16, sub16;
    logic [15:0] a16, b16, out1, out2;
    logic        busy1, done1, cout1, ovf1, zero1;
    logic        busy2, done2, cout2, ovf2, zero2;

    adder_seq_nbit #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .reset(reset0), .start(start0), .a(a0), .b(b0), .carry_in(cin0),
        .sub(sub0), .busy(busy0), .done(done0), .out(out0), .carry_out(cout0),
        .overflow(ovf0), .zero(zero0)
    );

    adder_seq_nbit #(.WIDTH(16), .CHUNK(4)) u_dut1 (
        .clk(clk), .reset(reset16), .start(start16), .a(a16), .b(b16), .carry_in(cin16),
        .sub(sub16), .busy(busy1), .done(done1), .out(out1), .carry_out(cout1),
        .overflow(ovf1), .zero(zero1)
    );

    adder_seq_nbit #(.WIDTH(16), .CHUNK(16)) u_dut2 (
        .clk(clk), .reset(reset16), .start(start16), .a(a16), .b(b16), .carry_in(cin16),
        .sub(sub16), .busy(busy2), .done(done2), .out(out2), .carry_out(cout2),
        .overflow(ovf2), .zero(zero2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic s);
        exp_t        e;
        logic [32:0] mask, be, sum;
        mask  = (33'd1 << w) - 33'd1;
        be    = s ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
        sum   = ({1'b0, a} & mask) + be + {32'd0, (s ? 1'b1 : cin)};
        e.res = sum[31:0] & mask[31:0];
        e.c   = sum[w];
        if (s) e.v = (a[w-1] != b[w-1]) && (e.res[w-1] != a[w-1]);
        else   e.v = (a[w-1] == b[w-1]) && (e.res[w-1] != a[w-1]);
        e.z   = (e.res == 32'd0);
        e.e0  = 0;
        return e;
    endfunction

    task automatic check_done(input string tag, input exp_t e, input logic [31:0] res,
                              input logic c, input logic v, input logic z, input logic busy,
                              input int lat, input int want_lat, input logic prev_done);
        chk({tag, "_out"}, res, e.res);
        chk({tag, "_carry_out"}, {31'd0, c}, {31'd0, e.c});
        chk({tag, "_overflow"}, {31'd0, v}, {31'd0, e.v});
        chk({tag, "_zero"}, {31'd0, z}, {31'd0, e.z});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_latency"}, lat, want_lat);
        chk({tag, "_done_one_cycle"}, {31'd0, prev_done}, 32'd0);
    endtask

    // Monitors: pop and compare whenever a DUT pulses done.
    initial begin
        exp_t e;
        logic pd = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done0) begin
                    if (q0.size() == 0) fail_now("dut0_spurious_done", "done=1 with no pending op");
                    else begin
                        e = q0.pop_front();
                        check_done("dut0", e, out0, cout0, ovf0, zero0, busy0, cyc - e.e0, 4, pd);
                    end
                    held0 = out0;
                end else begin
                    chk("dut0_out_hold", out0, held0);
                end
                pd = done0;
            end
        end
    end

    initial begin
        exp_t e;
        logic pd = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done1) begin
                    if (q1.size() == 0) fail_now("dut1_spurious_done", "done=1 with no pending op");
                    else begin
                        e = q1.pop_front();
                        check_done("dut1", e, {16'd0, out1}, cout1, ovf1, zero1, busy1,
                                   cyc - e.e0, 4, pd);
                    end
                end
                pd = done1;
            end
        end
    end

    initial begin
        exp_t e;
        logic pd = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done2) begin
                    if (q2.size() == 0) fail_now("dut2_spurious_done", "done=1 with no pending op");
                    else begin
                        e = q2.pop_front();
                        check_done("dut2", e, {16'd0, out2}, cout2, ovf2, zero2, busy2,
                                   cyc - e.e0, 1, pd);
                    end
                end
                pd = done2;
            end
        end
    end

    task automatic wait_idle0();
        int k = 0;
        while ((busy0 || done0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) fail_now("dut0_idle_timeout", "never returned to idle");
    endtask

    // Issue one op on the 32-bit DUT; poke holds start high through BUSY and DONE.
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic s, input logic [31:0] r, input logic c, input logic v,
                        input logic z, input bit poke);
        exp_t e;
        int   k;
        wait_idle0();
        a0 = a; b0 = b; cin0 = cin; sub0 = s; start0 = 1'b1;
        @(posedge clk);
        #1;
        e.res = r; e.c = c; e.v = v; e.z = z; e.e0 = cyc;
        q0.push_back(e);
        start0 = poke;
        a0 = $urandom; b0 = $urandom; cin0 = 1'($urandom); sub0 = 1'($urandom);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            if (done0) break;
            chk("dut0_busy_during_op", {31'd0, busy0}, 32'd1);
            k++;
        end
        if (k == 40) fail_now("dut0_done_timeout", "done never asserted");
        @(posedge clk);
        #1;
        start0 = 1'b0;
    endtask

    task automatic rand32();
        exp_t        e;
        logic [31:0] a, b;
        logic        cin, s;
        a = $urandom; b = $urandom; cin = 1'($urandom); s = 1'($urandom);
        e = model(32, a, b, cin, s);
        op32(a, b, cin, s, e.res, e.c, e.v, e.z, 1'b0);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic s, input bit use_model, input logic [15:0] r);
        exp_t e;
        int   k = 0;
        while ((busy1 || done1 || busy2 || done2) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) fail_now("dut16_idle_timeout", "never returned to idle");
        a16 = a; b16 = b; cin16 = cin; sub16 = s; start16 = 1'b1;
        @(posedge clk);
        #1;
        e = model(16, {16'd0, a}, {16'd0, b}, cin, s);
        if (!use_model) e.res = {16'd0, r};
        e.e0 = cyc;
        q1.push_back(e);
        q2.push_back(e);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
        k = 0;
        while (!done1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k == 40) fail_now("dut1_done_timeout", "done never asserted");
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset0 = 1'b1; start0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0;
        reset16 = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset0 = 1'b0;
        reset16 = 1'b0;
        @(negedge clk);
        chk("reset_busy0", {31'd0, busy0}, 32'd0);
        chk("reset_done0", {31'd0, done0}, 32'd0);
        chk("reset_out0", out0, 32'd0);
        chk("reset_flags0", {29'd0, cout0, ovf0, zero0}, 32'd0);
        chk("reset_out1", {16'd0, out1}, 32'd0);
        chk("reset_out2", {16'd0, out2}, 32'd0);
        held0  = '0;
        mon_en = 1'b1;

        // Directed 32-bit vectors: a, b, cin, sub -> out, carry, overflow, zero
        op32(32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        op32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        op32(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        op32(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        op32(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        op32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation, asserted for edge E0+2
        wait_idle0();
        a0 = 32'h1234_5678; b0 = 32'h1111_1111; cin0 = 1'b0; sub0 = 1'b0; start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        @(posedge clk);
        #1;
        reset0 = 1'b1;
        @(posedge clk);
        #1;
        reset0 = 1'b0;
        held0  = '0;
        @(negedge clk);
        chk("midreset_busy0", {31'd0, busy0}, 32'd0);
        chk("midreset_done0", {31'd0, done0}, 32'd0);
        chk("midreset_out0", out0, 32'd0);
        chk("midreset_flags0", {29'd0, cout0, ovf0, zero0}, 32'd0);

        op32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);
        // start held high through BUSY and DONE must not launch a second op
        op32(32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0, 32'h0000_0124, 1'b0, 1'b0, 1'b0, 1'b1);
        op32(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) rand32();

        // 16-bit configurations
        op16(16'h4844, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h6A66);
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000);
        op16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 1000; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 16'h0000);
        end

        repeat (10) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
